// File: rtl/multu_unit.sv
// Radix-2 shift-add unsigned multiplier for the EX stage: executes MULTU,
// holds HI/LO and freezes the front of the pipeline until the product lands.
module multu_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH:0]   r_acc;
  logic [WIDTH:0]   w_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  // Partial-product add; the extra acc bit keeps the carry out of the add.
  always_comb begin
    w_sum  = r_acc + (r_mplier[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
    w_last = (r_cnt == CNT_LAST);
  end

  // Next-state logic; DONE always returns to IDLE so start there is ignored.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_BUSY;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_BUSY: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_BUSY;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath: operand capture in IDLE, one shift-add per BUSY cycle,
  // HI/LO written only on the final iteration so they never show partial results.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= {WIDTH{1'b0}};
      r_mplier <= {WIDTH{1'b0}};
      r_acc    <= {(WIDTH+1){1'b0}};
      r_cnt    <= {CNT_W{1'b0}};
      r_hi     <= {WIDTH{1'b0}};
      r_lo     <= {WIDTH{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand  <= a;
            r_mplier <= b;
            r_acc    <= {(WIDTH+1){1'b0}};
            r_cnt    <= {CNT_W{1'b0}};
          end
        end
        S_BUSY: begin
          r_acc    <= {1'b0, w_sum[WIDTH:1]};
          r_mplier <= {w_sum[0], r_mplier[WIDTH-1:1]};
          r_cnt    <= r_cnt + CNT_ONE;
          if (w_last) begin
            r_hi <= w_sum[WIDTH:1];
            r_lo <= {w_sum[0], r_mplier[WIDTH-1:1]};
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy  = (r_state == S_BUSY);
  assign done  = (r_state == S_DONE);
  // Combinational so the MULTU is frozen in the very cycle it is recognised.
  assign stall = ~rst & (((r_state == S_IDLE) & start) | (r_state == S_BUSY));
  assign hi    = r_hi;
  assign lo    = r_lo;

endmodule

// File: tb/tb_multu_unit.sv
// Scoreboard bench for multu_unit: driver pushes a*b per issued MULTU,
// monitor pops on done and tracks the architectural HI/LO every cycle.
module tb_multu_unit;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         stall;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_checks;
  int n_errors;

  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] mdl_hilo;
  logic           mon_en;
  logic           rst_at_edge;

  multu_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .stall (stall),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: reset clears the model, done retires the oldest expected product.
  always @(posedge clk) rst_at_edge <= rst;

  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_at_edge) begin
        mdl_hilo = {2*W{1'b0}};
        exp_q.delete();
        chk("done_after_rst", {63'd0, done}, 64'd0);
      end else if (done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL spurious_done: got done=1, expected no pending product at %0t", $time);
        end else begin
          mdl_hilo = exp_q.pop_front();
        end
      end
      chk("hilo", {hi, lo}, mdl_hilo);
    end
  end

  task automatic ctl_chk(input string name, input logic s, input logic bz, input logic d);
    chk(name, {61'd0, stall, busy, done}, {61'd0, s, bz, d});
  endtask

  // garble: 0 hold operands and start=1, 1 random noise, 2 operands=0xDEADBEEF
  task automatic do_mul(input logic [W-1:0] x, input logic [W-1:0] y, input int garble);
    logic [2*W-1:0] prod;
    @(negedge clk);
    start = 1'b1;
    a = x;
    b = y;
    prod = 64'(x) * 64'(y);
    exp_q.push_back(prod);
    #1;
    ctl_chk("ctl_cycle0", 1'b1, 1'b0, 1'b0);
    for (int cyc = 1; cyc <= W + 1; cyc++) begin
      @(negedge clk);
      if (garble == 1) begin
        a = $urandom;
        b = $urandom;
        start = 1'($urandom_range(0, 1));
      end else if (garble == 2) begin
        a = 32'hDEADBEEF;
        b = 32'hDEADBEEF;
      end
      #1;
      if (cyc <= W) ctl_chk("ctl_busy", 1'b1, 1'b1, 1'b0);
      else          ctl_chk("ctl_done", 1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
      a = $urandom;
      b = $urandom;
      #1;
      ctl_chk("ctl_idle", 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic abort_mul(input logic [W-1:0] x, input logic [W-1:0] y, input int at_cyc);
    @(negedge clk);
    start = 1'b1;
    a = x;
    b = y;
    exp_q.push_back(64'(x) * 64'(y));
    for (int cyc = 1; cyc <= at_cyc; cyc++) @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    ctl_chk("ctl_after_abort", 1'b0, 1'b0, 1'b0);
    chk("hilo_after_abort", {hi, lo}, 64'd0);
  endtask

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'h0;
      1:       v = 32'hFFFFFFFF;
      2:       v = 32'h1 << $urandom_range(0, 31);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    mon_en   = 1'b0;
    mdl_hilo = {2*W{1'b0}};
    rst      = 1'b1;
    start    = 1'b1;
    a        = 32'd3;
    b        = 32'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("stall_in_rst", {63'd0, stall}, 64'd0);
    end
    @(negedge clk);
    rst    = 1'b0;
    start  = 1'b0;
    mon_en = 1'b1;
    #1;
    ctl_chk("ctl_reset", 1'b0, 1'b0, 1'b0);
    chk("hilo_reset", {hi, lo}, 64'd0);
    idle(2);

    do_mul(32'd3, 32'd5, 0);
    do_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    do_mul(32'h80000000, 32'd2, 0);
    idle(1);
    do_mul(32'd6, 32'd7, 2);
    idle(1);
    do_mul(32'd2, 32'd3, 0);
    do_mul(32'h00010000, 32'h00010000, 0);
    do_mul(32'h80000001, 32'd2, 0);
    abort_mul(32'h12345678, 32'h9ABCDEF0, 10);
    idle(40);
    do_mul(32'd0, 32'h12345678, 0);
    idle(100);

    for (int k = 0; k < 20; k++) begin
      do_mul(pick_operand(), pick_operand(), 1);
      idle($urandom_range(0, 2));
    end
    idle(3);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
